// File: rtl/irq_ctrl_if.sv
// Software configuration port of the interrupt controller: a four-register
// bus with a write strobe and a combinational read-back.
interface irq_ctrl_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_we,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_rdata
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt and exception controller: synchronises external lines, latches
// pending edges, and steers the decoder FSM into microcode state 0 on requests.
module irq_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_in,
    input  logic            fault,
    input  logic            syscall,
    input  logic            reti,
    input  logic [3:0]      cpu_state,
    irq_ctrl_if.slave       cfg,
    output logic            irq_r,
    output logic            fault_r,
    output logic [3:0]      cause,
    output logic            in_service
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    localparam logic [3:0] CAUSE_SYSCALL = 4'd14;
    localparam logic [3:0] CAUSE_FAULT   = 4'd15;

    state_t          state;
    logic [NSRC-1:0] s1, s2, s3;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pending;
    logic            gie;
    logic            pgie;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] req_vec;
    logic [3:0]      lowest;
    logic [NSRC-1:0] accept_clr;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] pending_next;
    logic            accept;
    logic            sys_eff;
    logic            reti_eff;
    logic            hw_event;
    logic            mask_wr;
    logic            ctrl_wr;
    logic            unused_wdata;

    assign rise    = s2 & ~s3;
    assign req_vec = pending & mask;

    // Fault outranks syscall, which outranks acceptance and reti.
    assign accept   = (state == REQ) && (cpu_state == 4'd0) && !fault && !syscall;
    assign sys_eff  = syscall && (state != SERVICE) && !fault;
    assign reti_eff = reti && (state == SERVICE) && !fault;
    assign hw_event = fault || sys_eff || accept || reti_eff;

    assign mask_wr = cfg.cfg_we && (cfg.cfg_addr == 2'd0);
    assign ctrl_wr = cfg.cfg_we && (cfg.cfg_addr == 2'd3);
    assign w1c     = (cfg.cfg_we && (cfg.cfg_addr == 2'd1)) ? cfg.cfg_wdata[NSRC-1:0] : '0;

    assign unused_wdata = ^cfg.cfg_wdata[15:NSRC];

    always_comb begin
        lowest = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                lowest = 4'(i);
            end
        end
    end

    always_comb begin
        accept_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            accept_clr[i] = accept && (cause == 4'(i));
        end
    end

    // A fresh edge on a bit beats both software W1C and acceptance clearing it.
    assign pending_next = (pending & ~w1c & ~accept_clr) | rise;

    always_comb begin
        cfg.cfg_rdata = 16'h0000;
        case (cfg.cfg_addr)
            2'd0: cfg.cfg_rdata[NSRC-1:0] = mask;
            2'd1: cfg.cfg_rdata[NSRC-1:0] = pending;
            2'd2: cfg.cfg_rdata = {in_service, 11'b0, cause};
            default: cfg.cfg_rdata[1:0] = {pgie, gie};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            mask       <= '0;
            pending    <= '0;
            gie        <= 1'b0;
            pgie       <= 1'b0;
            irq_r      <= 1'b0;
            fault_r    <= 1'b0;
            cause      <= 4'd0;
            in_service <= 1'b0;
        end else begin
            s1      <= irq_in;
            s2      <= s1;
            s3      <= s2;
            pending <= pending_next;
            fault_r <= 1'b0;

            if (mask_wr) begin
                mask <= cfg.cfg_wdata[NSRC-1:0];
            end
            if (ctrl_wr && !hw_event) begin
                gie <= cfg.cfg_wdata[0];
            end

            // A nested fault keeps PGIE so the outer handler's enable survives.
            if (fault) begin
                fault_r    <= 1'b1;
                irq_r      <= 1'b0;
                cause      <= CAUSE_FAULT;
                in_service <= 1'b1;
                state      <= SERVICE;
                if (state != SERVICE) begin
                    pgie <= gie;
                    gie  <= 1'b0;
                end
            end else if (sys_eff) begin
                irq_r      <= 1'b0;
                cause      <= CAUSE_SYSCALL;
                in_service <= 1'b1;
                pgie       <= gie;
                gie        <= 1'b0;
                state      <= SERVICE;
            end else begin
                case (state)
                    IDLE: begin
                        if (gie && (req_vec != '0)) begin
                            cause <= lowest;
                            irq_r <= 1'b1;
                            state <= REQ;
                        end
                    end
                    REQ: begin
                        if (accept) begin
                            irq_r      <= 1'b0;
                            pgie       <= gie;
                            gie        <= 1'b0;
                            in_service <= 1'b1;
                            state      <= SERVICE;
                        end
                    end
                    SERVICE: begin
                        if (reti_eff) begin
                            gie        <= pgie;
                            in_service <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: stimulus pushes expectations into queues and a
// negedge monitor pops and compares them against the observed outputs.
module tb_irq_ctrl;

    localparam int NSRC = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] val;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [NSRC-1:0] irq_in;
    logic            fault;
    logic            syscall;
    logic            reti;
    logic [3:0]      cpu_state;
    logic            irq_r;
    logic            fault_r;
    logic [3:0]      cause;
    logic            in_service;

    logic            stim_we;
    logic [1:0]      stim_addr;
    logic [15:0]     stim_wdata;
    logic            mon_override;
    logic [1:0]      mon_addr;

    exp_t exp_q[$];
    int   irq_q[$];
    int   fault_q[$];
    int   vectors;
    int   miscompares;

    irq_ctrl_if cfg ();

    assign cfg.cfg_we    = stim_we;
    assign cfg.cfg_wdata = stim_wdata;
    assign cfg.cfg_addr  = mon_override ? mon_addr : stim_addr;

    irq_ctrl #(.NSRC(NSRC)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .fault      (fault),
        .syscall    (syscall),
        .reti       (reti),
        .cpu_state  (cpu_state),
        .cfg        (cfg),
        .irq_r      (irq_r),
        .fault_r    (fault_r),
        .cause      (cause),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
        end
    endtask

    // Sel: 0 irq_r, 1 fault_r, 2 cause, 3 in_service, 4..7 config register 0..3.
    task automatic expect_val(input string name, input int sel, input logic [15:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data);
        stim_we    = 1'b1;
        stim_addr  = addr;
        stim_wdata = data;
        tick(1);
        stim_we    = 1'b0;
        stim_wdata = 16'h0000;
    endtask

    // One-cycle pulses on the interrupt lines and decoder strobes.
    task automatic apply_stimulus(input logic [NSRC-1:0] irq, input logic flt,
                                  input logic sys, input logic rt);
        irq_in  = irq;
        fault   = flt;
        syscall = sys;
        reti    = rt;
        tick(1);
        irq_in  = '0;
        fault   = 1'b0;
        syscall = 1'b0;
        reti    = 1'b0;
    endtask

    task automatic accept_request();
        cpu_state = 4'd0;
        tick(1);
        cpu_state = 4'd7;
    endtask

    initial begin : monitor
        logic        prev_irq;
        logic        m_irq, m_fault, m_svc;
        logic [3:0]  m_cause;
        logic [15:0] rd [4];
        logic [15:0] act;
        exp_t        e;
        int          ec;
        prev_irq     = 1'b0;
        mon_override = 1'b0;
        mon_addr     = 2'd0;
        forever begin
            @(negedge clk);
            m_irq   = irq_r;
            m_fault = fault_r;
            m_cause = cause;
            m_svc   = in_service;
            mon_override = 1'b1;
            for (int a = 0; a < 4; a++) begin
                mon_addr = 2'(a);
                #1;
                rd[a] = cfg.cfg_rdata;
            end
            mon_override = 1'b0;

            if (m_irq && !prev_irq) begin
                if (irq_q.size() == 0) begin
                    check_output("unexpected_irq_r", {15'b0, m_irq}, 16'h0000);
                end else begin
                    ec = irq_q.pop_front();
                    check_output("irq_cause", {12'b0, m_cause}, 16'(ec));
                end
            end
            prev_irq = m_irq;

            if (m_fault) begin
                if (fault_q.size() == 0) begin
                    check_output("unexpected_fault_r", {15'b0, m_fault}, 16'h0000);
                end else begin
                    ec = fault_q.pop_front();
                    check_output("fault_cause", {12'b0, m_cause}, 16'(ec));
                end
            end

            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.sel)
                    0: act = {15'b0, m_irq};
                    1: act = {15'b0, m_fault};
                    2: act = {12'b0, m_cause};
                    3: act = {15'b0, m_svc};
                    default: act = rd[(e.sel - 4) & 3];
                endcase
                check_output(e.name, act, e.val);
            end
        end
    end

    initial begin : watchdog
        #200000;
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : stimulus
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        irq_in      = '0;
        fault       = 1'b0;
        syscall     = 1'b0;
        reti        = 1'b0;
        cpu_state   = 4'd7;
        stim_we     = 1'b0;
        stim_addr   = 2'd0;
        stim_wdata  = 16'h0000;

        tick(2);
        expect_val("rst_irq_r", 0, 16'h0000);
        expect_val("rst_fault_r", 1, 16'h0000);
        expect_val("rst_cause", 2, 16'h0000);
        expect_val("rst_in_service", 3, 16'h0000);
        expect_val("rst_mask", 4, 16'h0000);
        expect_val("rst_pending", 5, 16'h0000);
        expect_val("rst_cause_reg", 6, 16'h0000);
        expect_val("rst_ctrl", 7, 16'h0000);
        tick(1);
        reset = 1'b0;

        $display("[TB] single source request and acceptance");
        cfg_write(2'd0, 16'h0001);
        cfg_write(2'd3, 16'h0001);
        irq_q.push_back(0);
        apply_stimulus(8'h01, 1'b0, 1'b0, 1'b0);
        tick(2);
        expect_val("t1_pending_set", 5, 16'h0001);
        expect_val("t1_irq_not_yet", 0, 16'h0000);
        tick(1);
        expect_val("t1_irq_r", 0, 16'h0001);
        expect_val("t1_cause", 2, 16'h0000);
        tick(3);
        expect_val("t1_irq_held", 0, 16'h0001);
        accept_request();
        expect_val("t1_irq_dropped", 0, 16'h0000);
        expect_val("t1_pending_clr", 5, 16'h0000);
        expect_val("t1_ctrl", 7, 16'h0002);
        expect_val("t1_in_service", 3, 16'h0001);
        expect_val("t1_cause_reg", 6, 16'h8000);
        apply_stimulus('0, 1'b0, 1'b0, 1'b1);
        expect_val("t1_reti_ctrl", 7, 16'h0003);
        expect_val("t1_reti_svc", 3, 16'h0000);

        $display("[TB] two simultaneous sources");
        cfg_write(2'd0, 16'h0024);
        irq_q.push_back(2);
        irq_q.push_back(5);
        apply_stimulus(8'h24, 1'b0, 1'b0, 1'b0);
        tick(2);
        expect_val("t2_pending", 5, 16'h0024);
        tick(1);
        expect_val("t2_cause_first", 2, 16'h0002);
        accept_request();
        expect_val("t2_pending_after", 5, 16'h0020);
        expect_val("t2_cause_reg", 6, 16'h8002);
        apply_stimulus('0, 1'b0, 1'b0, 1'b1);
        expect_val("t2_idle_gap", 0, 16'h0000);
        tick(1);
        expect_val("t2_second_irq", 0, 16'h0001);
        expect_val("t2_cause_second", 2, 16'h0005);
        expect_val("t2_pending_second", 5, 16'h0020);
        accept_request();
        expect_val("t2_pending_final", 5, 16'h0000);
        apply_stimulus('0, 1'b0, 1'b0, 1'b1);

        $display("[TB] fault during request");
        cfg_write(2'd0, 16'h0008);
        irq_q.push_back(3);
        irq_q.push_back(3);
        apply_stimulus(8'h08, 1'b0, 1'b0, 1'b0);
        tick(3);
        expect_val("t3_cause_req", 2, 16'h0003);
        fault_q.push_back(15);
        apply_stimulus('0, 1'b1, 1'b0, 1'b0);
        expect_val("t3_fault_r", 1, 16'h0001);
        expect_val("t3_cause", 2, 16'h000F);
        expect_val("t3_irq_r", 0, 16'h0000);
        expect_val("t3_pending_kept", 5, 16'h0008);
        expect_val("t3_cause_reg", 6, 16'h800F);
        expect_val("t3_ctrl", 7, 16'h0002);
        tick(1);
        expect_val("t3_fault_r_1cyc", 1, 16'h0000);
        apply_stimulus('0, 1'b0, 1'b0, 1'b1);
        expect_val("t3_reti_ctrl", 7, 16'h0003);
        tick(1);
        expect_val("t3_rerequest", 0, 16'h0001);
        accept_request();
        expect_val("t3_pending_clr", 5, 16'h0000);
        apply_stimulus('0, 1'b0, 1'b0, 1'b1);

        $display("[TB] global enable gating");
        cfg_write(2'd3, 16'h0000);
        cfg_write(2'd0, 16'h0002);
        apply_stimulus(8'h02, 1'b0, 1'b0, 1'b0);
        tick(3);
        expect_val("t4_pending", 5, 16'h0002);
        expect_val("t4_irq_gated", 0, 16'h0000);
        tick(2);
        expect_val("t4_irq_still_gated", 0, 16'h0000);
        irq_q.push_back(1);
        cfg_write(2'd3, 16'h0001);
        expect_val("t4_irq_lag", 0, 16'h0000);
        tick(1);
        expect_val("t4_irq_enabled", 0, 16'h0001);
        accept_request();
        apply_stimulus('0, 1'b0, 1'b0, 1'b1);

        $display("[TB] edge versus write-1-to-clear");
        cfg_write(2'd0, 16'h0000);
        apply_stimulus(8'h02, 1'b0, 1'b0, 1'b0);
        tick(3);
        expect_val("t5_pending_pre", 5, 16'h0002);
        apply_stimulus(8'h02, 1'b0, 1'b0, 1'b0);
        tick(1);
        cfg_write(2'd1, 16'h0002);
        expect_val("t5_set_wins", 5, 16'h0002);
        cfg_write(2'd1, 16'h0002);
        expect_val("t5_w1c", 5, 16'h0000);

        $display("[TB] syscall then reset mid-handler");
        apply_stimulus('0, 1'b0, 1'b1, 1'b0);
        expect_val("t6_sys_cause", 2, 16'h000E);
        expect_val("t6_sys_svc", 3, 16'h0001);
        expect_val("t6_sys_irq", 0, 16'h0000);
        expect_val("t6_sys_ctrl", 7, 16'h0002);
        tick(1);
        #1;
        reset = 1'b1;
        expect_val("t6_rst_irq_r", 0, 16'h0000);
        expect_val("t6_rst_cause", 2, 16'h0000);
        expect_val("t6_rst_svc", 3, 16'h0000);
        expect_val("t6_rst_ctrl", 7, 16'h0000);
        expect_val("t6_rst_cause_reg", 6, 16'h0000);
        tick(1);
        reset = 1'b0;
        apply_stimulus('0, 1'b0, 1'b0, 1'b1);
        expect_val("t6_reti_svc", 3, 16'h0000);
        expect_val("t6_reti_ctrl", 7, 16'h0000);
        expect_val("t6_reti_cause", 2, 16'h0000);
        tick(3);

        check_output("irq_events_drained", 16'(irq_q.size()), 16'h0000);
        check_output("fault_events_drained", 16'(fault_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
